ceu_result_collector: RTL and testbench

Receive-side companion to the CEU lanes. It accepts the stream of covariance elements the CEUs emit, each as a DBL_WIDTH-bit word with a one-cycle valid strobe, in fixed upper-triangular row-major order. It assembles the words into a symmetric N×N matrix in a ping-pong pair of triangular banks. It then serves random (row, col) reads of a completed bank to the downstream gain stage while the other bank fills.

---
 rtl/ceu_result_collector.sv | 157 +++++++++++++++
 tb/tb_ceu_result_collector.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ceu_result_collector.sv
// Collects the CEU upper-triangular covariance stream into ping-pong triangular banks
// and serves symmetric (row, col) reads. Optional macro: CEU_COLLECT_DIAG_CHECK_EN.
module ceu_result_collector #(
  parameter int DBL_WIDTH = 64,
  parameter int N         = 12,
  localparam int DEPTH    = N * (N + 1) / 2,
  localparam int IDX_W    = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DBL_WIDTH-1:0] in_data,
  output logic                 in_ready,
  output logic                 overflow_err,
  output logic                 matrix_done,
  output logic                 bank_ready,
  input  logic                 bank_release,
  input  logic                 rd_req,
  input  logic [IDX_W-1:0]     rd_row,
  input  logic [IDX_W-1:0]     rd_col,
  output logic                 rd_valid,
  output logic [DBL_WIDTH-1:0] rd_data,
  output logic                 diag_err
);

  localparam int WIDX_W = $clog2(DEPTH);
  localparam int ADDR_W = $clog2(2 * DEPTH);
  localparam int OFF_W  = ADDR_W + 2;

  logic                 wb_q, wb_d, rb_q, rb_d;
  logic [1:0]           full_q, full_d;
  logic [IDX_W-1:0]     wr_r_q, wr_r_d, wr_c_q, wr_c_d;
  logic [WIDX_W-1:0]    wr_idx_q, wr_idx_d;
  logic                 overflow_q, overflow_d;
  logic                 done_q, done_d;
  logic                 rd_valid_q, rd_ok_q;
  logic [DBL_WIDTH-1:0] rd_raw_q;

  // Both banks share one array; bank 1 occupies the upper DEPTH words.
  logic [DBL_WIDTH-1:0] mem [2*DEPTH];

  logic accept, last_elem, release_ok;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  assign accept     = in_valid && !full_q[wb_q];
  assign last_elem  = (wr_r_q == IDX_W'(N - 1)) && (wr_c_q == IDX_W'(N - 1));
  assign release_ok = bank_release && full_q[rb_q];
  assign wr_addr    = ADDR_W'(wr_idx_q) + (wb_q ? ADDR_W'(DEPTH) : ADDR_W'(0));

  always_comb begin
    wb_d       = wb_q;
    rb_d       = rb_q;
    full_d     = full_q;
    wr_r_d     = wr_r_q;
    wr_c_d     = wr_c_q;
    wr_idx_d   = wr_idx_q;
    done_d     = 1'b0;
    overflow_d = overflow_q | (in_valid & full_q[wb_q]);
    if (accept) begin
      if (last_elem) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
        wr_r_d       = '0;
        wr_c_d       = '0;
        wr_idx_d     = '0;
        done_d       = 1'b1;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
        if (wr_c_q == IDX_W'(N - 1)) begin
          // Next row of the upper triangle starts on its diagonal.
          wr_r_d = wr_r_q + 1'b1;
          wr_c_d = wr_r_q + 1'b1;
        end else begin
          wr_c_d = wr_c_q + 1'b1;
        end
      end
    end
    if (release_ok) begin
      full_d[rb_q] = 1'b0;
      rb_d         = ~rb_q;
    end
  end

  logic [IDX_W-1:0] rd_lo, rd_hi;
  logic             rd_in_range;
  logic [OFF_W-1:0] rd_base, rd_off;

  always_comb begin
    if (rd_row <= rd_col) begin
      rd_lo = rd_row;
      rd_hi = rd_col;
    end else begin
      rd_lo = rd_col;
      rd_hi = rd_row;
    end
    rd_in_range = ({1'b0, rd_row} < (IDX_W + 1)'(N)) && ({1'b0, rd_col} < (IDX_W + 1)'(N));
    // Row base r*N - r*(r-1)/2 rewritten as r*(2N+1-r)/2 to stay non-negative.
    rd_base = (OFF_W'(rd_lo) * (OFF_W'(2 * N + 1) - OFF_W'(rd_lo))) >> 1;
    rd_off  = rd_base + OFF_W'(rd_hi) - OFF_W'(rd_lo) + (rb_q ? OFF_W'(DEPTH) : OFF_W'(0));
    rd_addr = rd_in_range ? ADDR_W'(rd_off) : '0;
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_addr] <= in_data;
    if (rd_req) rd_raw_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      full_q     <= 2'b00;
      wr_r_q     <= '0;
      wr_c_q     <= '0;
      wr_idx_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_ok_q    <= 1'b0;
    end else begin
      wb_q       <= wb_d;
      rb_q       <= rb_d;
      full_q     <= full_d;
      wr_r_q     <= wr_r_d;
      wr_c_q     <= wr_c_d;
      wr_idx_q   <= wr_idx_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      rd_valid_q <= rd_req;
      rd_ok_q    <= rd_req && full_q[rb_q] && rd_in_range;
    end
  end

  assign in_ready     = ~full_q[wb_q];
  assign bank_ready   = full_q[rb_q];
  assign overflow_err = overflow_q;
  assign matrix_done  = done_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_ok_q ? rd_raw_q : '0;

`ifdef CEU_COLLECT_DIAG_CHECK_EN
  logic diag_q;
  // A covariance diagonal must be strictly positive: flag negatives and +/-0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diag_q <= 1'b0;
    end else if (accept && (wr_r_q == wr_c_q) &&
                 (in_data[DBL_WIDTH-1] || (in_data[DBL_WIDTH-2:0] == '0))) begin
      diag_q <= 1'b1;
    end
  end
  assign diag_err = diag_q;
`else
  assign diag_err = 1'b0;
`endif

endmodule

// File: tb/tb_ceu_result_collector.sv
// Scoreboard bench for ceu_result_collector: random streams and reads checked against
// a matrix-level reference model (queue of completed symmetric matrices).
module tb_ceu_result_collector;
  localparam int N     = 12;
  localparam int DEPTH = N * (N + 1) / 2;
`ifdef CEU_COLLECT_DIAG_CHECK_EN
  localparam bit DIAG_EN = 1'b1;
`else
  localparam bit DIAG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_ready, overflow_err, matrix_done, bank_ready;
  logic        bank_release = 1'b0;
  logic        rd_req = 1'b0;
  logic [3:0]  rd_row = '0, rd_col = '0;
  logic        rd_valid;
  logic [63:0] rd_data;
  logic        diag_err;

  ceu_result_collector #(.DBL_WIDTH(64), .N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .overflow_err(overflow_err), .matrix_done(matrix_done), .bank_ready(bank_ready),
    .bank_release(bank_release), .rd_req(rd_req), .rd_row(rd_row), .rd_col(rd_col),
    .rd_valid(rd_valid), .rd_data(rd_data), .diag_err(diag_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: completed matrices in arrival order, plus the partial stream.
  logic [63:0] mat [2][N][N];
  int          head = 0, cnt = 0;
  logic [63:0] cur [$];
  bit          ovf_exp = 0, diag_exp = 0, done_exp = 0;

  logic [63:0] exp_q [$];
  int          due_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit is_diag(input int k);
    int p = 0;
    for (int r = 0; r < N; r++)
      for (int c = r; c < N; c++) begin
        if (p == k) return (r == c);
        p++;
      end
    return 1'b0;
  endfunction

  function automatic logic [63:0] model_read(input int r, input int c);
    if (cnt == 0 || r >= N || c >= N) return 64'h0;
    return mat[head][r][c];
  endfunction

  task automatic model_write(input logic [63:0] d);
    int slot, p;
    if (cnt == 2) begin
      ovf_exp = 1;
      return;
    end
    if (DIAG_EN && is_diag(cur.size()) && (d[63] || d[62:0] == 63'h0)) diag_exp = 1;
    cur.push_back(d);
    if (cur.size() == DEPTH) begin
      slot = (head + cnt) % 2;
      p = 0;
      for (int r = 0; r < N; r++)
        for (int c = r; c < N; c++) begin
          mat[slot][r][c] = cur[p];
          mat[slot][c][r] = cur[p];
          p++;
        end
      cnt++;
      cur.delete();
      done_exp = 1;
      $display("matrix completed into model slot %0d at cycle %0d", slot, cyc);
    end
  endtask

  task automatic cycle(input bit v, input logic [63:0] d, input bit rel,
                       input bit rq, input int r, input int c);
    in_valid = v; in_data = d; bank_release = rel; rd_req = rq;
    rd_row = 4'(r); rd_col = 4'(c);
    if (rq) begin
      exp_q.push_back(model_read(r, c));
      due_q.push_back(cyc + 1);
    end
    @(posedge clk);
    done_exp = 0;
    if (v) model_write(d);
    if (rel && cnt > 0) begin
      head = head ^ 1;
      cnt--;
    end
    #1;
    in_valid = 0; bank_release = 0; rd_req = 0;
    check("matrix_done", matrix_done, done_exp);
    check("bank_ready", bank_ready, cnt > 0);
    check("in_ready", in_ready, cnt < 2);
    check("overflow_err", overflow_err, ovf_exp);
    check("diag_err", diag_err, diag_exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input int r, input int c);
    cycle(0, 0, 0, 1, r, c);
  endtask

  task automatic do_reset();
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    head = 0; cnt = 0; cur.delete();
    ovf_exp = 0; diag_exp = 0; done_exp = 0;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    bit due;
    logic [63:0] e;
    due = (due_q.size() > 0) && (due_q[0] == cyc);
    if (rd_valid || due) begin
      check("rd_valid", rd_valid, due);
      if (due) begin
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        check("rd_data", rd_data, e);
        $display("read response %h (expected %h) cycle %0d", rd_data, e, cyc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_rd_data", rd_data, 0);
    rst = 0;
    #1;
    check("reset_overflow", overflow_err, 0);
    check("reset_done", matrix_done, 0);
    check("reset_bank_ready", bank_ready, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_diag", diag_err, 0);
    @(posedge clk); #1;

    // Boundary: read and release with no completed bank.
    rd(0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    idle(1);

    // Symmetric readback.
    for (int k = 0; k < DEPTH; k++) cycle(1, 64'(k), 0, 0, 0, 0);
    rd(1, 3); rd(3, 1); rd(11, 11); rd(0, 0); rd(12, 0);
    for (int i = 0; i < 20; i++) rd($urandom_range(0, 13), $urandom_range(0, 13));

    // Ping-pong fill of the second bank without release.
    for (int k = 0; k < DEPTH; k++) cycle(1, 64'(k + 100), 0, 0, 0, 0);
    rd(0, 1);
    cycle(0, 0, 1, 1, 0, 1);
    rd(0, 1); rd(5, 2);

    // Refill freed bank, then overflow with both full.
    for (int k = 0; k < DEPTH; k++) cycle(1, rnd64(), 0, 0, 0, 0);
    cycle(1, 64'hDEAD, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    // Completion and release on the same edge.
    for (int k = 0; k < DEPTH - 1; k++) cycle(1, rnd64(), 0, 0, 0, 0);
    cycle(1, rnd64(), 1, 0, 0, 0);
    for (int i = 0; i < 15; i++) rd($urandom_range(0, 11), $urandom_range(0, 11));
    cycle(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) rd($urandom_range(0, 11), $urandom_range(0, 11));
    idle(2);

    // Reset mid-epoch.
    do_reset();
    for (int k = 0; k < 40; k++) cycle(1, rnd64(), 0, 0, 0, 0);
    idle(1);
    do_reset();
    for (int k = 0; k < DEPTH; k++) cycle(1, {1'b0, 31'($urandom), $urandom} | 64'h1, 0, 0, 0, 0);
    rd(0, 0); rd(11, 0);
    idle(2);

    // Diagonal check: negative first diagonal, then a clean positive stream.
    do_reset();
    cycle(1, 64'hBFF0000000000000, 0, 0, 0, 0);
    idle(1);
    do_reset();
    cycle(1, 64'h3FF0000000000000, 0, 0, 0, 0);
    for (int k = 1; k < DEPTH; k++) cycle(1, {1'b0, 31'($urandom), $urandom} | 64'h1, 0, 0, 0, 0);
    rd(4, 4);
    idle(3);

    check("rd_queue_drained", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
